// File: rtl/alu_issue_arbiter.sv
// Shares one fixed-latency ALU among REQUESTERS clients; results are routed back by tag.
// Define ALU_ISSUE_ARB_ROTATE_EN for round-robin arbitration (default: fixed priority).
module alu_issue_arbiter #(
  parameter int REQUESTERS   = 8,
  parameter int TAG_WIDTH    = 3,
  parameter int OPCODE_WIDTH = 4,
  parameter int WORD_WIDTH   = 36,
  parameter int ALU_LATENCY  = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [REQUESTERS-1:0]              req,
  input  logic [REQUESTERS*OPCODE_WIDTH-1:0] req_op,
  input  logic [REQUESTERS*WORD_WIDTH-1:0]   req_A,
  input  logic [REQUESTERS*WORD_WIDTH-1:0]   req_B,
  output logic [REQUESTERS-1:0]              grant,
  output logic [OPCODE_WIDTH-1:0]            alu_op,
  output logic [WORD_WIDTH-1:0]              alu_A,
  output logic [WORD_WIDTH-1:0]              alu_B,
  output logic                               alu_valid,
  input  logic [WORD_WIDTH-1:0]              alu_R,
  output logic                               rsp_valid,
  output logic [TAG_WIDTH-1:0]               rsp_tag,
  output logic [WORD_WIDTH-1:0]              rsp_R,
  input  logic                               drain,
  output logic                               drained
);

  localparam int CNT_WIDTH = $clog2(ALU_LATENCY + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(ALU_LATENCY);

  localparam logic [1:0] ST_RUN     = 2'd0;  // RUN     | grants allowed
  localparam logic [1:0] ST_DRAIN   = 2'd1;  // DRAIN   | no grants, waiting for in-flight results
  localparam logic [1:0] ST_DRAINED = 2'd2;  // DRAINED | no grants, nothing in flight

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [REQUESTERS-1:0]   pending;
  logic [REQUESTERS-1:0]   rsp_clear;
  logic [CNT_WIDTH-1:0]    inflight;
  logic [CNT_WIDTH-1:0]    inflight_nxt;
  logic [REQUESTERS-1:0]   eligible;
  logic                    issue_ok;
  logic [REQUESTERS-1:0]   grant_vec;
  logic [TAG_WIDTH-1:0]    grant_idx;
  logic                    grant_any;

  logic                    valid_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [WORD_WIDTH-1:0]   a_q;
  logic [WORD_WIDTH-1:0]   b_q;

  logic [ALU_LATENCY-1:0]  dl_valid;
  logic [TAG_WIDTH-1:0]    dl_tag [ALU_LATENCY];
  logic                    rsp_q;
  logic [TAG_WIDTH-1:0]    rsp_tag_q;

  assign rsp_q     = dl_valid[ALU_LATENCY-1];
  assign rsp_tag_q = dl_tag[ALU_LATENCY-1];

  // The capacity term only binds when REQUESTERS exceeds ALU_LATENCY.
  assign issue_ok = (state == ST_RUN) && !drain && !reset &&
                    ((inflight < CNT_MAX) || rsp_q);
  assign eligible = req & ~pending & {REQUESTERS{issue_ok}};

`ifdef ALU_ISSUE_ARB_ROTATE_EN
  logic [TAG_WIDTH-1:0] rr_ptr;

  always_comb begin
    int idx;
    idx       = 0;
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < REQUESTERS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (!grant_any && eligible[idx]) begin
        grant_any      = 1'b1;
        grant_vec[idx] = 1'b1;
        grant_idx      = TAG_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (int'(grant_idx) == REQUESTERS - 1) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (!grant_any && eligible[k]) begin
        grant_any    = 1'b1;
        grant_vec[k] = 1'b1;
        grant_idx    = TAG_WIDTH'(k);
      end
    end
  end
`endif

  assign grant = grant_vec;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= grant_any;
      tag_q   <= grant_idx;
      if (grant_any) begin
        op_q <= req_op[grant_idx*OPCODE_WIDTH +: OPCODE_WIDTH];
        a_q  <= req_A[grant_idx*WORD_WIDTH +: WORD_WIDTH];
        b_q  <= req_B[grant_idx*WORD_WIDTH +: WORD_WIDTH];
      end else begin
        op_q <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dl_valid <= '0;
      for (int i = 0; i < ALU_LATENCY; i++) dl_tag[i] <= '0;
    end else begin
      dl_valid[0] <= valid_q;
      dl_tag[0]   <= tag_q;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_tag[i]   <= dl_tag[i-1];
      end
    end
  end

  always_comb begin
    rsp_clear = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      rsp_clear[i] = rsp_q && (int'(rsp_tag_q) == i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending | grant_vec) & ~rsp_clear;
    end
  end

  always_comb begin
    inflight_nxt = inflight;
    if (grant_any && !rsp_q) begin
      inflight_nxt = inflight + 1'b1;
    end else if (!grant_any && rsp_q) begin
      inflight_nxt = inflight - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      inflight <= inflight_nxt;
    end
  end

  // Drained is judged on the post-update count so it rises the cycle after the last response.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (drain) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain) state_nxt = ST_RUN;
        else if (inflight_nxt == '0) state_nxt = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Synchronous clear lands only at the edge, so outputs are also held quiet while reset is high.
  assign alu_valid = valid_q & ~reset;
  assign alu_op    = reset ? '0 : op_q;
  assign alu_A     = reset ? '0 : a_q;
  assign alu_B     = reset ? '0 : b_q;
  assign rsp_valid = rsp_q & ~reset;
  assign rsp_tag   = reset ? '0 : rsp_tag_q;
  assign rsp_R     = alu_R;
  assign drained   = (state == ST_DRAINED) && !reset;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: directed scenarios push expected grant/ALU/response
// events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_alu_issue_arbiter;
  localparam int REQUESTERS   = 8;
  localparam int TAG_WIDTH    = 3;
  localparam int OPCODE_WIDTH = 4;
  localparam int WORD_WIDTH   = 36;
  localparam int ALU_LATENCY  = 8;

  logic                               clock = 1'b0;
  logic                               reset;
  logic [REQUESTERS-1:0]              req;
  logic [REQUESTERS*OPCODE_WIDTH-1:0] req_op;
  logic [REQUESTERS*WORD_WIDTH-1:0]   req_A;
  logic [REQUESTERS*WORD_WIDTH-1:0]   req_B;
  logic [REQUESTERS-1:0]              grant;
  logic [OPCODE_WIDTH-1:0]            alu_op;
  logic [WORD_WIDTH-1:0]              alu_A;
  logic [WORD_WIDTH-1:0]              alu_B;
  logic                               alu_valid;
  logic [WORD_WIDTH-1:0]              alu_R;
  logic                               rsp_valid;
  logic [TAG_WIDTH-1:0]               rsp_tag;
  logic [WORD_WIDTH-1:0]              rsp_R;
  logic                               drain;
  logic                               drained;

  alu_issue_arbiter #(
    .REQUESTERS(REQUESTERS), .TAG_WIDTH(TAG_WIDTH), .OPCODE_WIDTH(OPCODE_WIDTH),
    .WORD_WIDTH(WORD_WIDTH), .ALU_LATENCY(ALU_LATENCY)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op), .req_A(req_A), .req_B(req_B),
    .grant(grant), .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B), .alu_valid(alu_valid),
    .alu_R(alu_R), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_R(rsp_R),
    .drain(drain), .drained(drained)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; int tag; } ev_t;
  typedef struct { int cyc; logic [OPCODE_WIDTH-1:0] op; logic [WORD_WIDTH-1:0] a; logic [WORD_WIDTH-1:0] b; } alu_ev_t;
  typedef struct { int cyc; bit level; } lvl_ev_t;

  ev_t     exp_grant[$];
  ev_t     exp_rsp[$];
  alu_ev_t exp_alu[$];
  lvl_ev_t exp_drn[$];

  int checks = 0;
  int errors = 0;
  int t;

  function automatic logic [OPCODE_WIDTH-1:0] op_of(input int i);
    return OPCODE_WIDTH'(i + 1);
  endfunction
  function automatic logic [WORD_WIDTH-1:0] a_of(input int i);
    return {4'(i), 32'hA5A5_0000 + 32'(i)};
  endfunction
  function automatic logic [WORD_WIDTH-1:0] b_of(input int i);
    return {4'(15 - i), 32'h0F0F_1000 + 32'(i * 7)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic exp_issue(input int tag, input int at, input bit with_alu, input bit with_rsp);
    ev_t e;
    alu_ev_t a;
    e.cyc = at;
    e.tag = tag;
    exp_grant.push_back(e);
    if (with_alu) begin
      a.cyc = at + 1;
      a.op  = op_of(tag);
      a.a   = a_of(tag);
      a.b   = b_of(tag);
      exp_alu.push_back(a);
    end
    if (with_rsp) begin
      e.cyc = at + 1 + ALU_LATENCY;
      exp_rsp.push_back(e);
    end
  endtask

  task automatic exp_drained(input int at, input bit level);
    lvl_ev_t d;
    d.cyc   = at;
    d.level = level;
    exp_drn.push_back(d);
  endtask

  bit prev_reset   = 1'b1;
  bit prev_drained = 1'b0;

  always @(negedge clock) begin
    ev_t     e;
    alu_ev_t a;
    lvl_ev_t d;
    logic [REQUESTERS-1:0] gexp;
    if (reset) begin
      chk("reset_grant", grant, 0);
      chk("reset_alu_valid", alu_valid, 0);
      chk("reset_alu_op", alu_op, 0);
      chk("reset_alu_A", alu_A, 0);
      chk("reset_alu_B", alu_B, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_tag", rsp_tag, 0);
      chk("reset_drained", drained, 0);
    end else begin
      if (prev_reset) begin
        chk("post_reset_alu_valid", alu_valid, 0);
        chk("post_reset_alu_op", alu_op, 0);
        chk("post_reset_alu_A", alu_A, 0);
        chk("post_reset_alu_B", alu_B, 0);
        chk("post_reset_rsp_valid", rsp_valid, 0);
        chk("post_reset_rsp_tag", rsp_tag, 0);
        chk("post_reset_drained", drained, 0);
      end
      chk("grant_onehot0", $onehot0(grant), 1);
      chk("inflight_vs_pending", dut.inflight, $countones(dut.pending));
      if (grant != '0) begin
        if (exp_grant.size() == 0) begin
          chk("grant_unexpected", grant, 0);
        end else begin
          e = exp_grant.pop_front();
          gexp = '0;
          gexp[e.tag] = 1'b1;
          chk("grant_cycle", cyc, e.cyc);
          chk("grant_vec", grant, gexp);
        end
      end
      if (alu_valid) begin
        if (exp_alu.size() == 0) begin
          chk("alu_valid_unexpected", alu_valid, 0);
        end else begin
          a = exp_alu.pop_front();
          chk("alu_cycle", cyc, a.cyc);
          chk("alu_op", alu_op, a.op);
          chk("alu_A", alu_A, a.a);
          chk("alu_B", alu_B, a.b);
        end
      end else begin
        chk("alu_op_idle", alu_op, 0);
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_valid_unexpected", rsp_valid, 0);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_tag", rsp_tag, e.tag);
          chk("rsp_R_passthrough", rsp_R, alu_R);
        end
      end
      if (drained != prev_drained) begin
        if (exp_drn.size() == 0) begin
          chk("drained_unexpected_edge", drained, prev_drained);
        end else begin
          d = exp_drn.pop_front();
          chk("drained_edge_cycle", cyc, d.cyc);
          chk("drained_edge_level", drained, d.level);
        end
      end
    end
    prev_reset   = reset;
    prev_drained = drained;
  end

  initial begin
    alu_R = '0;
    forever begin
      @(posedge clock);
      #1;
      alu_R = {4'hC, 32'(cyc) * 32'h0101_0101};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    drain = 1'b0;
    for (int i = 0; i < REQUESTERS; i++) begin
      req_op[i*OPCODE_WIDTH +: OPCODE_WIDTH] = op_of(i);
      req_A[i*WORD_WIDTH +: WORD_WIDTH]      = a_of(i);
      req_B[i*WORD_WIDTH +: WORD_WIDTH]      = b_of(i);
    end
    tick(3);
    reset = 1'b0;
    tick(2);

    // All requesters contend right after reset: 0..7 in order, then 0 again once it returns.
    t = cyc;
    req = 8'hFF;
    for (int i = 0; i < REQUESTERS; i++) exp_issue(i, t + i, 1'b1, 1'b1);
    exp_issue(0, t + 10, 1'b1, 1'b1);
    tick(11);
    req = '0;
    tick(12);

    // Single requester held: response at +9, regrant at +10.
    t = cyc;
    req = 8'b0000_0100;
    exp_issue(2, t, 1'b1, 1'b1);
    exp_issue(2, t + 10, 1'b1, 1'b1);
    tick(11);
    req = '0;
    tick(12);

    // Two requesters held.
    t = cyc;
    req = 8'b0000_0011;
    exp_issue(0, t, 1'b1, 1'b1);
    exp_issue(1, t + 1, 1'b1, 1'b1);
    exp_issue(0, t + 10, 1'b1, 1'b1);
    exp_issue(1, t + 11, 1'b1, 1'b1);
    tick(12);
    req = '0;
    tick(12);

    // Three in flight when drain rises; the same-cycle request from 3 is blocked.
    t = cyc;
    req = 8'h20;
    exp_issue(5, t, 1'b1, 1'b1);
    tick(1);
    req = 8'h40;
    exp_issue(6, t + 1, 1'b1, 1'b1);
    tick(1);
    req = 8'h80;
    exp_issue(7, t + 2, 1'b1, 1'b1);
    tick(1);
    req   = 8'h08;
    drain = 1'b1;
    exp_drained(t + 12, 1'b1);
    exp_drained(t + 16, 1'b0);
    exp_issue(3, t + 16, 1'b1, 1'b1);
    tick(12);
    drain = 1'b0;
    tick(2);
    req = '0;
    tick(12);

    // Requesters 0 and 1 become eligible together after 0 was the last grant.
    t = cyc;
    req = 8'b0000_0001;
    exp_issue(0, t, 1'b1, 1'b1);
    tick(1);
    req = '0;
    tick(11);
`ifdef ALU_ISSUE_ARB_ROTATE_EN
    exp_issue(1, t + 12, 1'b1, 1'b1);
    exp_issue(0, t + 13, 1'b1, 1'b1);
`else
    exp_issue(0, t + 12, 1'b1, 1'b1);
    exp_issue(1, t + 13, 1'b1, 1'b1);
`endif
    req = 8'b0000_0011;
    tick(2);
    req = '0;
    tick(10);

    // Five in flight, one-cycle reset: no stale responses, everyone eligible at once.
    t = cyc;
    for (int i = 0; i < 5; i++) begin
      req = 8'(1 << i);
      exp_issue(i, t + i, i < 4, 1'b0);
      tick(1);
    end
    reset = 1'b1;
    req   = 8'hFF;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < REQUESTERS; i++) exp_issue(i, t + 6 + i, 1'b1, 1'b1);
    tick(8);
    req = '0;
    tick(12);

    chk("grant_events_left", exp_grant.size(), 0);
    chk("alu_events_left", exp_alu.size(), 0);
    chk("rsp_events_left", exp_rsp.size(), 0);
    chk("drained_events_left", exp_drn.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
